// File: rtl/accel_uart_sequencer.sv
// Runs one 3x3 matrix-vector job on the datapath, then streams the latched
// results as a framed byte sequence through a single shared UART transmitter.
module accel_uart_sequencer #(
  parameter int         BYTE_GAP  = 10000,
  parameter int         TIMEOUT   = 1024,
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter bit         SEND_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_req,
  output logic        acc_start,
  input  logic        acc_done,
  input  logic [15:0] y1,
  input  logic [15:0] y2,
  input  logic [15:0] y3,
  output logic [7:0]  tx_data,
  output logic        tx_transmit,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (BYTE_GAP > 2) ? $clog2(BYTE_GAP) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(BYTE_GAP - 2);
  localparam logic [2:0]    LAST_IDX = SEND_HIGH ? 3'd6 : 3'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_SEND      = 3'd3,
    S_GAP       = 3'd4,
    S_FINISH    = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [2:0]      idx_r;
  logic [2:0]      next_idx_s;
  logic            start_q_r;
  logic            done_q_r;
  logic            start_rise_s;
  logic            done_rise_s;
  logic [TW-1:0]   to_cnt_r;
  logic [GW-1:0]   gap_cnt_r;
  logic [15:0]     y1_r;
  logic [15:0]     y2_r;
  logic [15:0]     y3_r;
  logic [7:0]      next_byte_s;
  logic            next_busy_s;
  logic            acc_start_r;
  logic [7:0]      tx_data_r;
  logic            tx_transmit_r;
  logic            busy_r;
  logic            frame_done_r;
  logic            timeout_err_r;

  // Byte idx of the frame, built from the latched results.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [15:0] c);
    logic [7:0] res;
    res = 8'h00;
    if (SEND_HIGH) begin
      case (idx)
        3'd0:    res = HEADER;
        3'd1:    res = a[15:8];
        3'd2:    res = a[7:0];
        3'd3:    res = b[15:8];
        3'd4:    res = b[7:0];
        3'd5:    res = c[15:8];
        3'd6:    res = c[7:0];
        default: res = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    res = HEADER;
        3'd1:    res = a[7:0];
        3'd2:    res = b[7:0];
        3'd3:    res = c[7:0];
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

  assign start_rise_s = start_req & ~start_q_r;
  assign done_rise_s  = acc_done & ~done_q_r;

  // Edge-detect history for the two request levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q_r <= 1'b0;
      done_q_r  <= 1'b0;
    end else begin
      start_q_r <= start_req;
      done_q_r  <= acc_done;
    end
  end

  // Next-state and byte-index selection.
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (start_rise_s) next_state_s = S_LAUNCH;
        else              next_state_s = S_IDLE;
      end
      S_LAUNCH: next_state_s = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // A done edge on the final count cycle still counts as success.
        if (done_rise_s) begin
          next_state_s = S_SEND;
          next_idx_s   = 3'd0;
        end else if (to_cnt_r == TO_LAST) begin
          next_state_s = S_ERROR;
        end else begin
          next_state_s = S_WAIT_DONE;
        end
      end
      S_SEND: next_state_s = S_GAP;
      S_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          if (idx_r == LAST_IDX) begin
            next_state_s = S_FINISH;
          end else begin
            next_state_s = S_SEND;
            next_idx_s   = idx_r + 3'd1;
          end
        end else begin
          next_state_s = S_GAP;
        end
      end
      S_FINISH: next_state_s = S_IDLE;
      S_ERROR: begin
        if (start_rise_s) next_state_s = S_LAUNCH;
        else              next_state_s = S_ERROR;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Busy flag and outgoing byte for the state being entered.
  always_comb begin
    next_byte_s = frame_byte(next_idx_s, y1_r, y2_r, y3_r);
    case (next_state_s)
      S_LAUNCH, S_WAIT_DONE, S_SEND, S_GAP, S_FINISH: next_busy_s = 1'b1;
      default:                                        next_busy_s = 1'b0;
    endcase
  end

  // State and byte-index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      idx_r   <= 3'd0;
    end else begin
      state_r <= next_state_s;
      idx_r   <= next_idx_s;
    end
  end

  // Timeout and inter-byte gap counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_r  <= '0;
      gap_cnt_r <= '0;
    end else begin
      if (state_r == S_LAUNCH)         to_cnt_r <= '0;
      else if (state_r == S_WAIT_DONE) to_cnt_r <= to_cnt_r + 1'b1;
      else                             to_cnt_r <= to_cnt_r;
      if (state_r == S_SEND)           gap_cnt_r <= '0;
      else if (state_r == S_GAP)       gap_cnt_r <= gap_cnt_r + 1'b1;
      else                             gap_cnt_r <= gap_cnt_r;
    end
  end

  // Result capture on the accepted done edge; later y changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y1_r <= 16'h0000;
      y2_r <= 16'h0000;
      y3_r <= 16'h0000;
    end else if (state_r == S_WAIT_DONE && done_rise_s) begin
      y1_r <= y1;
      y2_r <= y2;
      y3_r <= y3;
    end else begin
      y1_r <= y1_r;
      y2_r <= y2_r;
      y3_r <= y3_r;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_start_r   <= 1'b0;
      tx_data_r     <= 8'h00;
      tx_transmit_r <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      acc_start_r   <= (next_state_s == S_LAUNCH);
      tx_transmit_r <= (next_state_s == S_SEND);
      busy_r        <= next_busy_s;
      frame_done_r  <= (next_state_s == S_FINISH);
      timeout_err_r <= (next_state_s == S_ERROR);
      if (next_state_s == S_SEND) tx_data_r <= next_byte_s;
      else                        tx_data_r <= tx_data_r;
    end
  end

  assign acc_start   = acc_start_r;
  assign tx_data     = tx_data_r;
  assign tx_transmit = tx_transmit_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_accel_uart_sequencer.sv
// Drives two sequencers (7-byte and 4-byte frames) with identical stimulus and
// checks frame contents and timing against expectations built from the frame rules.
module tb_accel_uart_sequencer;

  localparam int G  = 20;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_req = 1'b0;
  logic        acc_done = 1'b0;
  logic [15:0] y1 = 16'h0, y2 = 16'h0, y3 = 16'h0;

  logic       acc_start_h, tx_transmit_h, busy_h, frame_done_h, timeout_err_h;
  logic [7:0] tx_data_h;
  logic       acc_start_l, tx_transmit_l, busy_l, frame_done_l, timeout_err_l;
  logic [7:0] tx_data_l;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  int tx_q_h[$], txc_q_h[$], st_q_h[$], fd_q_h[$];
  int tx_q_l[$], txc_q_l[$], st_q_l[$], fd_q_l[$];

  accel_uart_sequencer #(.BYTE_GAP(G), .TIMEOUT(TO), .HEADER(8'hA5), .SEND_HIGH(1'b1)) dut_h (
    .clk(clk), .reset(rst_n), .start_req(start_req), .acc_start(acc_start_h),
    .acc_done(acc_done), .y1(y1), .y2(y2), .y3(y3), .tx_data(tx_data_h),
    .tx_transmit(tx_transmit_h), .busy(busy_h), .frame_done(frame_done_h),
    .timeout_err(timeout_err_h));

  accel_uart_sequencer #(.BYTE_GAP(G), .TIMEOUT(TO), .HEADER(8'hA5), .SEND_HIGH(1'b0)) dut_l (
    .clk(clk), .reset(rst_n), .start_req(start_req), .acc_start(acc_start_l),
    .acc_done(acc_done), .y1(y1), .y2(y2), .y3(y3), .tx_data(tx_data_l),
    .tx_transmit(tx_transmit_l), .busy(busy_l), .frame_done(frame_done_l),
    .timeout_err(timeout_err_l));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: every pulse is logged with the cycle it was seen in.
  always @(negedge clk) begin
    if (tx_transmit_h) begin tx_q_h.push_back(int'(tx_data_h)); txc_q_h.push_back(cyc); end
    if (tx_transmit_l) begin tx_q_l.push_back(int'(tx_data_l)); txc_q_l.push_back(cyc); end
    if (acc_start_h)  st_q_h.push_back(cyc);
    if (acc_start_l)  st_q_l.push_back(cyc);
    if (frame_done_h) fd_q_h.push_back(cyc);
    if (frame_done_l) fd_q_l.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    tx_q_h.delete(); txc_q_h.delete(); st_q_h.delete(); fd_q_h.delete();
    tx_q_l.delete(); txc_q_l.delete(); st_q_l.delete(); fd_q_l.delete();
  endtask

  // Compare one DUT's logged frame with the expected byte list and schedule.
  task automatic verify(input bit hi, input int s, input int d,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    int bq[$]; int cq[$]; int sq[$]; int fq[$];
    logic [7:0] e[7];
    int n;
    string nm;
    if (hi) begin
      bq = tx_q_h; cq = txc_q_h; sq = st_q_h; fq = fd_q_h; n = 7; nm = "h";
      e = '{8'hA5, a[15:8], a[7:0], b[15:8], b[7:0], c[15:8], c[7:0]};
    end else begin
      bq = tx_q_l; cq = txc_q_l; sq = st_q_l; fq = fd_q_l; n = 4; nm = "l";
      e = '{8'hA5, a[7:0], b[7:0], c[7:0], 8'h00, 8'h00, 8'h00};
    end
    check($sformatf("%s.n_start", nm), sq.size(), 1);
    if (sq.size() > 0) check($sformatf("%s.start_cyc", nm), sq[0] - s, 1);
    check($sformatf("%s.n_bytes", nm), bq.size(), n);
    for (int k = 0; k < n && k < bq.size(); k++) begin
      check($sformatf("%s.byte%0d", nm, k), bq[k], e[k]);
      check($sformatf("%s.byte%0d_cyc", nm, k), cq[k] - d, 1 + k * G);
    end
    check($sformatf("%s.n_frame_done", nm), fq.size(), 1);
    if (fq.size() > 0) check($sformatf("%s.frame_done_cyc", nm), fq[0] - d, 1 + n * G);
  endtask

  // One complete job: start edge, done edge after dly cycles, full frame.
  task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input int dly, input bit mutate, input bit pre_done);
    int s, d;
    clear_log();
    if (pre_done) begin
      @(negedge clk); acc_done = 1'b1;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    y1 = a; y2 = b; y3 = c;
    start_req = 1'b1;
    s = cyc;
    repeat (dly) begin
      @(negedge clk);
      if (cyc == s + 1) begin
        check("launch.acc_start", {acc_start_h, acc_start_l}, 2'b11);
        check("launch.timeout_err", {timeout_err_h, timeout_err_l}, 2'b00);
        check("launch.busy", {busy_h, busy_l}, 2'b11);
      end
      if (cyc == s + 2) start_req = 1'b0;
      if (cyc == s + dly - 1) acc_done = 1'b0;
    end
    d = cyc;
    check("wait.no_tx", tx_q_h.size() + tx_q_l.size(), 0);
    acc_done = 1'b1;
    while (cyc < d + 7 * G + 4) begin
      @(negedge clk);
      if (mutate) begin
        if (cyc == d + 1) begin y1 = 16'hFFFF; y2 = 16'hFFFF; y3 = 16'hFFFF; end
        if (cyc == d + 5 || cyc == d + 40) start_req = 1'b1;
        if (cyc == d + 9 || cyc == d + 44) start_req = 1'b0;
      end
      if (cyc == d + 1 + 7 * G) check("h.busy_in_finish", busy_h, 1'b1);
      if (cyc == d + 2 + 7 * G) check("h.busy_after", busy_h, 1'b0);
      if (cyc == d + 2 + 4 * G) check("l.busy_after", busy_l, 1'b0);
    end
    acc_done = 1'b0;
    verify(1'b1, s, d, a, b, c);
    verify(1'b0, s, d, a, b, c);
  endtask

  initial begin
    int s, d;
    logic [15:0] ra, rb, rc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.h", {acc_start_h, tx_transmit_h, busy_h, frame_done_h, timeout_err_h, tx_data_h}, 13'h0);
    check("rst.l", {acc_start_l, tx_transmit_l, busy_l, frame_done_l, timeout_err_l, tx_data_l}, 13'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reference job, both frame formats
    run_job(16'd6, 16'd3, 16'd5, 10, 1'b0, 1'b0);

    // Timeout: acc_done never rises
    clear_log();
    @(negedge clk);
    start_req = 1'b1;
    s = cyc;
    while (cyc < s + TO + 1) begin
      @(negedge clk);
      if (cyc == s + 2) start_req = 1'b0;
    end
    check("to.err_before", {timeout_err_h, timeout_err_l}, 2'b00);
    check("to.busy_before", {busy_h, busy_l}, 2'b11);
    @(negedge clk);
    check("to.err_set", {timeout_err_h, timeout_err_l}, 2'b11);
    check("to.busy_clear", {busy_h, busy_l}, 2'b00);
    repeat (10) @(negedge clk);
    check("to.err_sticky", {timeout_err_h, timeout_err_l}, 2'b11);
    check("to.no_tx", tx_q_h.size() + tx_q_l.size(), 0);
    check("to.one_start", st_q_h.size() + st_q_l.size(), 2);
    // Retry from ERROR clears the flag and relaunches
    run_job(16'd6, 16'd3, 16'd5, 10, 1'b0, 1'b0);

    // acc_done held high from before the start
    run_job(16'd6, 16'd3, 16'd5, 10, 1'b0, 1'b1);

    // start toggles during the frame and y changes after capture
    run_job(16'd6, 16'd3, 16'd5, 10, 1'b1, 1'b0);

    // done edge on the last count cycle beats the timeout
    run_job(16'h1234, 16'hABCD, 16'h00FF, TO + 1, 1'b0, 1'b0);

    // Reset during the third byte's gap
    clear_log();
    ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
    @(negedge clk);
    y1 = ra; y2 = rb; y3 = rc;
    start_req = 1'b1;
    s = cyc;
    while (cyc < s + 5) begin
      @(negedge clk);
      if (cyc == s + 2) start_req = 1'b0;
    end
    acc_done = 1'b1;
    d = cyc;
    while (cyc < d + 1 + 2 * G + 7) @(negedge clk);
    check("mid.h_bytes", tx_q_h.size(), 3);
    check("mid.h_data", tx_data_h, ra[7:0]);
    check("mid.l_data", tx_data_l, rb[7:0]);
    check("mid.busy", {busy_h, busy_l}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_rst.h", {acc_start_h, tx_transmit_h, busy_h, frame_done_h, timeout_err_h, tx_data_h}, 13'h0);
    check("mid_rst.l", {acc_start_l, tx_transmit_l, busy_l, frame_done_l, timeout_err_l, tx_data_l}, 13'h0);
    @(negedge clk);
    acc_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_job(16'($urandom), 16'($urandom), 16'($urandom), 7, 1'b0, 1'b0);

    // Randomised jobs
    for (int j = 0; j < 5; j++) begin
      run_job(16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(17, 3)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
